// File: rtl/fifo_asynchronous_top.sv
// Dual-clock FIFO: binary/Gray pointers crossed through two-flop synchronizers,
// registered pessimistic Full (write domain) and Empty (read domain) flags.
// DEPTH must be a power of two and at least 4.
module fifo_asynchronous_top #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic             CLK_w,
    input  logic             CLK_r,
    input  logic             RST_n_w,
    input  logic             RST_n_r,
    input  logic             EN_w,
    input  logic [WIDTH-1:0] data_in,
    input  logic             EN_r,
    output logic [WIDTH-1:0] data_out,
    output logic             Full,
    output logic             Empty
);
    localparam int unsigned ADDR = $clog2(DEPTH);

    // Extra MSB is the wrap bit distinguishing full from empty.
    typedef logic [ADDR:0] ptr_t;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write domain state
    ptr_t wptr_q, wptr_d;
    ptr_t wgray_q, wgray_d;
    ptr_t rq1_q, rq2_q;
    logic full_q, full_d;
    logic wr_acc;

    // Read domain state
    ptr_t rptr_q, rptr_d;
    ptr_t rgray_q, rgray_d;
    ptr_t wq1_q, wq2_q;
    logic empty_q, empty_d;
    logic rd_acc;
    logic [WIDTH-1:0] dout_q, dout_d;

    // Write-side next state: accept, advance pointer, predict Full for the new pointer.
    always_comb begin
        wr_acc  = EN_w & ~full_q;
        wptr_d  = wptr_q + ptr_t'(wr_acc);
        wgray_d = wptr_d ^ (wptr_d >> 1);
        // Full when the write pointer is one lap ahead of the synchronized read pointer;
        // in Gray code that means the top two bits differ and the rest match.
        full_d  = (wgray_d == {~rq2_q[ADDR:ADDR-1], rq2_q[ADDR-2:0]});
    end

    // Write-domain registers, including the read-pointer synchronizer.
    always_ff @(posedge CLK_w or negedge RST_n_w) begin
        if (!RST_n_w) begin
            wptr_q  <= '0;
            wgray_q <= '0;
            rq1_q   <= '0;
            rq2_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            wgray_q <= wgray_d;
            rq1_q   <= rgray_q;
            rq2_q   <= rq1_q;
            full_q  <= full_d;
        end
    end

    // Storage array, written on accepted writes; deliberately not reset.
    always_ff @(posedge CLK_w) begin
        if (wr_acc) begin
            mem_q[wptr_q[ADDR-1:0]] <= data_in;
        end
    end

    // Read-side next state: accept, advance pointer, predict Empty, fetch the word.
    always_comb begin
        rd_acc  = EN_r & ~empty_q;
        rptr_d  = rptr_q + ptr_t'(rd_acc);
        rgray_d = rptr_d ^ (rptr_d >> 1);
        empty_d = (rgray_d == wq2_q);
        dout_d  = rd_acc ? mem_q[rptr_q[ADDR-1:0]] : dout_q;
    end

    // Read-domain registers, including the write-pointer synchronizer.
    always_ff @(posedge CLK_r or negedge RST_n_r) begin
        if (!RST_n_r) begin
            rptr_q  <= '0;
            rgray_q <= '0;
            wq1_q   <= '0;
            wq2_q   <= '0;
            empty_q <= 1'b1;
            dout_q  <= '0;
        end else begin
            rptr_q  <= rptr_d;
            rgray_q <= rgray_d;
            wq1_q   <= wgray_q;
            wq2_q   <= wq1_q;
            empty_q <= empty_d;
            dout_q  <= dout_d;
        end
    end

    assign data_out = dout_q;
    assign Full     = full_q;
    assign Empty    = empty_q;

endmodule

// File: tb/tb_fifo_asynchronous_top.sv
// Bench for fifo_asynchronous_top: queue model of accepted words plus
// directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_fifo_asynchronous_top;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 64;

    logic             clk_w = 1'b0;
    logic             clk_r = 1'b0;
    logic             rst_n_w;
    logic             rst_n_r;
    logic             en_w;
    logic [WIDTH-1:0] data_in;
    logic             en_r;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    always #5 clk_w = ~clk_w;
    always #8 clk_r = ~clk_r;

    fifo_asynchronous_top #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .CLK_w   (clk_w),
        .CLK_r   (clk_r),
        .RST_n_w (rst_n_w),
        .RST_n_r (rst_n_r),
        .EN_w    (en_w),
        .data_in (data_in),
        .EN_r    (en_r),
        .data_out(data_out),
        .Full    (full),
        .Empty   (empty)
    );

    int checks = 0;
    int passes = 0;

    // Model: words accepted but not yet read, expected data_out, log of words read.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] rd_log[$];
    logic [WIDTH-1:0] exp_dout;

    task automatic check(input bit ok, input string name,
                         input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model write side: record every word the FIFO is obliged to accept.
    always @(posedge clk_w) begin
        if (!rst_n_w && !rst_n_r) begin
            model_q.delete();
        end else if (rst_n_w && en_w && !full) begin
            if (model_q.size() >= DEPTH) check(1'b0, "write_accepted_while_full",
                                               WIDTH'(model_q.size()), WIDTH'(DEPTH));
            else model_q.push_back(data_in);
        end
    end

    // Model read side: an accepted read must return the oldest outstanding word.
    always @(posedge clk_r) begin
        if (!rst_n_r) begin
            exp_dout = '0;
        end else if (en_r && !empty) begin
            if (model_q.size() == 0) begin
                check(1'b0, "read_accepted_with_nothing_stored", 32'd0, 32'd1);
            end else begin
                exp_dout = model_q.pop_front();
                rd_log.push_back(exp_dout);
            end
        end
    end

    // Read-domain compare: data_out every cycle; Empty must be set when nothing is stored.
    always @(negedge clk_r) begin
        if (rst_n_r && rst_n_w) begin
            check(data_out === exp_dout, "data_out", data_out, exp_dout);
            if (model_q.size() == 0) check(empty === 1'b1, "empty_when_drained",
                                           WIDTH'(empty), 32'd1);
        end
    end

    // Write-domain compare: Full must be set when DEPTH words are outstanding.
    always @(negedge clk_w) begin
        if (rst_n_r && rst_n_w && model_q.size() == DEPTH)
            check(full === 1'b1, "full_when_depth_stored", WIDTH'(full), 32'd1);
    end

    // Write n words, EN_w gated by Full; value is base+i, or random when rnd is set.
    task automatic write_stream(input int n, input logic [WIDTH-1:0] base, input bit rnd);
        int i;
        int guard;
        i = 0;
        guard = 0;
        while (i < n && guard < 20000) begin
            @(negedge clk_w);
            guard++;
            if (!full) begin
                en_w = 1'b1;
                data_in = rnd ? WIDTH'($urandom) : base + WIDTH'(i);
                i++;
            end else begin
                en_w = 1'b0;
            end
        end
        @(negedge clk_w);
        en_w = 1'b0;
        check(i == n, "write_stream_done", WIDTH'(i), WIDTH'(n));
    endtask

    // Hold EN_r until the model has logged target reads, with a cycle bound.
    task automatic read_until(input int target, input int budget);
        int k;
        k = 0;
        @(negedge clk_r);
        en_r = 1'b1;
        while (rd_log.size() < target && k < budget) begin
            @(negedge clk_r);
            k++;
        end
        check(rd_log.size() == target, "read_count", WIDTH'(rd_log.size()), WIDTH'(target));
    endtask

    initial begin
        time tw;
        bit found;
        bit ok;
        int log0;

        rst_n_w = 1'b0;
        rst_n_r = 1'b0;
        en_w    = 1'b0;
        en_r    = 1'b0;
        data_in = '0;

        // Reset state
        repeat (4) @(negedge clk_r);
        check(full === 1'b0, "reset_full", WIDTH'(full), 32'd0);
        check(empty === 1'b1, "reset_empty", WIDTH'(empty), 32'd1);
        check(data_out === 32'd0, "reset_data_out", data_out, 32'd0);
        @(negedge clk_w);
        rst_n_w = 1'b1;
        rst_n_r = 1'b1;
        repeat (4) @(negedge clk_r);

        // Single word: Empty falls within 3 read edges, then one read returns it
        @(negedge clk_w);
        en_w = 1'b1;
        data_in = 32'hDEAD_BEEF;
        @(posedge clk_w);
        tw = $time;
        @(negedge clk_w);
        en_w = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge clk_r);
            if (!empty) found = 1'b1;
        end
        // Third read edge after the write is at most 48 ns later; seen 8 ns after that.
        check(found && ($time - tw) <= 56, "empty_fall_latency", WIDTH'($time - tw), 32'd56);
        en_r = 1'b1;
        @(negedge clk_r);
        en_r = 1'b0;
        check(data_out === 32'hDEAD_BEEF, "single_word_data", data_out, 32'hDEAD_BEEF);
        check(empty === 1'b1, "single_word_empty_after", WIDTH'(empty), 32'd1);

        // Overflow protection: 120 random words, reads start 7 read cycles later
        log0 = rd_log.size();
        fork
            write_stream(120, 32'd0, 1'b1);
            begin
                repeat (7) @(negedge clk_r);
                read_until(log0 + 120, 4000);
            end
        join
        en_r = 1'b0;
        check(model_q.size() == 0, "stream_model_drained", WIDTH'(model_q.size()), 32'd0);
        repeat (6) @(negedge clk_w);

        // Fill to full with reads idle; extra write while Full must be dropped
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_w);
            if (i == 63) check(full === 1'b0, "full_before_64th", WIDTH'(full), 32'd0);
            en_w = 1'b1;
            data_in = 32'h1000_0000 + WIDTH'(i);
        end
        @(negedge clk_w);
        check(full === 1'b1, "full_on_64th", WIDTH'(full), 32'd1);
        data_in = 32'h1234_5678;
        @(negedge clk_w);
        en_w = 1'b0;
        check(full === 1'b1, "full_held", WIDTH'(full), 32'd1);
        log0 = rd_log.size();
        read_until(log0 + 64, 400);
        en_r = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 64; k++)
            if (rd_log[log0 + k] !== 32'h1000_0000 + WIDTH'(k)) ok = 1'b0;
        check(ok, "fill_order", rd_log[log0], 32'h1000_0000);
        ok = 1'b1;
        for (int k = log0; k < rd_log.size(); k++)
            if (rd_log[k] === 32'h1234_5678) ok = 1'b0;
        check(ok, "dropped_write_absent", 32'h1234_5678, 32'd0);
        repeat (4) @(negedge clk_r);
        check(empty === 1'b1, "empty_after_fill_drain", WIDTH'(empty), 32'd1);
        repeat (6) @(negedge clk_w);

        // Wrap-around: 200 words with continuous reads
        log0 = rd_log.size();
        fork
            write_stream(200, 32'h2000_0000, 1'b0);
            read_until(log0 + 200, 6000);
        join
        ok = 1'b1;
        for (int k = 0; k < 200; k++)
            if (rd_log[log0 + k] !== 32'h2000_0000 + WIDTH'(k)) ok = 1'b0;
        check(ok, "wrap_order", rd_log[rd_log.size() - 1], 32'h2000_00C7);

        // Read when empty: EN_r stays high, data_out must hold the last word
        repeat (6) @(negedge clk_r);
        check(data_out === 32'h2000_00C7, "empty_read_holds", data_out, 32'h2000_00C7);
        check(empty === 1'b1, "empty_read_flag", WIDTH'(empty), 32'd1);
        log0 = rd_log.size();
        @(negedge clk_w);
        en_w = 1'b1;
        data_in = 32'hCAFE_F00D;
        @(negedge clk_w);
        en_w = 1'b0;
        for (int k = 0; k < 20 && rd_log.size() == log0; k++) @(negedge clk_r);
        en_r = 1'b0;
        check(rd_log.size() == log0 + 1, "next_word_read", WIDTH'(rd_log.size()),
              WIDTH'(log0 + 1));
        check(data_out === 32'hCAFE_F00D, "next_word_data", data_out, 32'hCAFE_F00D);

        // Reset mid-operation with words outstanding flushes both domains
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_w);
            en_w = 1'b1;
            data_in = 32'h3000_0000 + WIDTH'(i);
        end
        @(negedge clk_w);
        en_w = 1'b0;
        repeat (4) @(negedge clk_r);
        @(negedge clk_w);
        rst_n_w = 1'b0;
        rst_n_r = 1'b0;
        repeat (3) @(negedge clk_r);
        check(full === 1'b0, "midreset_full", WIDTH'(full), 32'd0);
        check(empty === 1'b1, "midreset_empty", WIDTH'(empty), 32'd1);
        check(data_out === 32'd0, "midreset_data_out", data_out, 32'd0);
        @(negedge clk_w);
        rst_n_w = 1'b1;
        rst_n_r = 1'b1;
        repeat (4) @(negedge clk_r);
        check(empty === 1'b1, "after_reset_empty", WIDTH'(empty), 32'd1);
        @(negedge clk_w);
        en_w = 1'b1;
        data_in = 32'hA5A5_A5A5;
        @(negedge clk_w);
        en_w = 1'b0;
        log0 = rd_log.size();
        read_until(log0 + 1, 20);
        @(negedge clk_r);
        en_r = 1'b0;
        check(data_out === 32'hA5A5_A5A5, "after_reset_data", data_out, 32'hA5A5_A5A5);
        repeat (4) @(negedge clk_r);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
